wb_sram_slave: RTL and testbench

Synthesizable Wishbone classic responder backed by a byte-writable single-port SRAM with a programmable wait-state count. It attaches to one slave port of the Wishbone intercon (wishbone_sN_* side) and is the first real target for the bus-functional master models used in the intercon bench. It provides on-chip scratch memory for SoC builds. With `WB_SRAM_SLAVE_ERR_EN` it also terminates out-of-window cycles with a bus error.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_sram_slave_mem.sv | 44 ++++
 rtl/wb_sram_slave.sv | 146 ++++++++++++++
 tb/tb_wb_sram_slave.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and the responder FSM state encoding.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_ADR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_sram_slave_mem.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Each byte lane is its own array so every lane maps onto a plain block RAM column.
module wb_sram_slave_mem
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [WB_SEL_W-1:0]   be_i,
    input  logic [WB_DATA_W-1:0]  wdata_i,
    input  logic                  re_i,
    output logic [WB_DATA_W-1:0]  rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        for (genvar gi = 0; gi < WB_SEL_W; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk_i) begin
                if (we_i && be_i[gi]) begin
                    mem_q[addr_i] <= wdata_i[8*gi +: 8];
                end
            end

            // Output register resets to zero but otherwise holds until the next read.
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    rd_q <= '0;
                end else if (re_i) begin
                    rd_q <= mem_q[addr_i];
                end
            end

            assign rdata_o[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder over byte-writable SRAM with programmable wait states.
// Define WB_SRAM_SLAVE_ERR_EN to add wishbone_err_o and out-of-window error termination.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [WB_ADR_W-1:0]  wishbone_adr_i,
    input  logic [WB_DATA_W-1:0] wishbone_dat_i,
    output logic [WB_DATA_W-1:0] wishbone_dat_o,
    input  logic [WB_SEL_W-1:0]  wishbone_sel_i,
    input  logic                 wishbone_we_i,
    input  logic                 wishbone_cyc_i,
    input  logic                 wishbone_stb_i,
    output logic                 wishbone_ack_o
`ifdef WB_SRAM_SLAVE_ERR_EN
    ,
    output logic                 wishbone_err_o
`endif
);

    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_t              state_q;
    logic [3:0]             cnt_q;
    logic [ADDR_WIDTH-1:0]  adr_q;
    logic                   we_q;
    logic [WB_SEL_W-1:0]    sel_q;
    logic [WB_DATA_W-1:0]   dat_q;
    logic                   ack_q;

    logic                   idle;
    logic                   req;
    logic                   enter_ack;
    logic                   eff_oor;
    logic                   eff_we;
    logic [ADDR_WIDTH-1:0]  eff_adr;
    logic [WB_SEL_W-1:0]    eff_sel;
    logic [WB_DATA_W-1:0]   eff_dat;
    logic                   mem_we;
    logic                   mem_re;

    assign idle = (state_q == IDLE);
    assign req  = idle && wishbone_cyc_i && wishbone_stb_i;

    // With zero wait states ACK is entered on the request edge, so the RAM must see the live bus.
    assign eff_adr = idle ? wishbone_adr_i[ADDR_WIDTH+1:2] : adr_q;
    assign eff_we  = idle ? wishbone_we_i  : we_q;
    assign eff_sel = idle ? wishbone_sel_i : sel_q;
    assign eff_dat = idle ? wishbone_dat_i : dat_q;

    assign enter_ack = (req && (WAIT_STATES == 0)) ||
                       ((state_q == WAIT) && wishbone_cyc_i && (cnt_q == 4'd0));

`ifdef WB_SRAM_SLAVE_ERR_EN
    logic oor_in;
    logic oor_q;
    logic err_q;
    logic unused_bits;

    assign oor_in  = (wishbone_adr_i[WB_ADR_W-1:ADDR_WIDTH+2] != BASE_ADDR[WB_ADR_W-1:ADDR_WIDTH+2]);
    assign eff_oor = idle ? oor_in : oor_q;
    assign wishbone_err_o = err_q;
    assign unused_bits = ^{wishbone_adr_i[1:0], BASE_ADDR[ADDR_WIDTH+1:0]};
`else
    logic unused_bits;

    assign eff_oor = 1'b0;
    assign unused_bits = ^{wishbone_adr_i[1:0], wishbone_adr_i[WB_ADR_W-1:ADDR_WIDTH+2], BASE_ADDR};
`endif

    // Reset gates the commit so a write pending at the reset edge is dropped.
    assign mem_we = sys_rst_n && enter_ack && eff_we && !eff_oor;
    assign mem_re = sys_rst_n && enter_ack && !eff_we && !eff_oor;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
`ifdef WB_SRAM_SLAVE_ERR_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= enter_ack && !eff_oor;
`ifdef WB_SRAM_SLAVE_ERR_EN
            err_q <= enter_ack && eff_oor;
`endif
            case (state_q)
                IDLE: begin
                    if (req) begin
                        adr_q <= wishbone_adr_i[ADDR_WIDTH+1:2];
                        we_q  <= wishbone_we_i;
                        sel_q <= wishbone_sel_i;
                        dat_q <= wishbone_dat_i;
`ifdef WB_SRAM_SLAVE_ERR_EN
                        oor_q <= oor_in;
`endif
                        if (WAIT_STATES == 0) begin
                            state_q <= ACK;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!wishbone_cyc_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wishbone_ack_o = ack_q;

    wb_sram_slave_mem #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .addr_i  (eff_adr),
        .we_i    (mem_we),
        .be_i    (eff_sel),
        .wdata_i (eff_dat),
        .re_i    (mem_re),
        .rdata_o (wishbone_dat_o)
    );

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench: three responders (WAIT_STATES 1, 3, 0) share one clock and reset;
// drivers queue expected terminations, a negedge monitor pops and checks them.
module tb_wb_sram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] adr [3];
    logic [31:0] dwr [3];
    logic [31:0] drd [3];
    logic [3:0]  sel [3];
    logic [2:0]  we, cyc, stb, ack, err;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int ws_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int WSV = (gi == 0) ? 1 : ((gi == 1) ? 3 : 0);
            wb_sram_slave #(
                .ADDR_WIDTH  (10),
                .WAIT_STATES (WSV),
                .BASE_ADDR   (32'h0000_0000)
            ) u_dut (
                .sys_clk        (clk),
                .sys_rst_n      (rst_n),
                .wishbone_adr_i (adr[gi]),
                .wishbone_dat_i (dwr[gi]),
                .wishbone_dat_o (drd[gi]),
                .wishbone_sel_i (sel[gi]),
                .wishbone_we_i  (we[gi]),
                .wishbone_cyc_i (cyc[gi]),
                .wishbone_stb_i (stb[gi]),
                .wishbone_ack_o (ack[gi])
`ifdef WB_SRAM_SLAVE_ERR_EN
                ,
                .wishbone_err_o (err[gi])
`endif
            );
`ifndef WB_SRAM_SLAVE_ERR_EN
            assign err[gi] = 1'b0;
`endif
        end
    endgenerate

    typedef struct {
        int          inst;
        int          at_cycle;
        bit          is_err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every termination must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ack[i] && err[i]) begin
                total++; bad++;
                $display("FAIL ack_err_both inst=%0d ack=%b err=%b required not both", i, ack[i], err[i]);
            end
            if (ack[i] || err[i]) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_term inst=%0d cycle=%0d ack=%b err=%b required none", i, cyc_cnt, ack[i], err[i]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.inst != i || mon_e.at_cycle != cyc_cnt || mon_e.is_err != err[i]) begin
                        bad++;
                        $display("FAIL term inst=%0d cycle=%0d err=%b required inst=%0d cycle=%0d err=%b",
                                 i, cyc_cnt, err[i], mon_e.inst, mon_e.at_cycle, mon_e.is_err);
                    end
                    if (mon_e.chk) begin
                        total++;
                        if (drd[i] !== mon_e.data) begin
                            bad++;
                            $display("FAIL rdata inst=%0d got=%h required=%h", i, drd[i], mon_e.data);
                        end
                    end
                    $display("txn inst=%0d cycle=%0d ack=%b err=%b dat_o=%h", i, cyc_cnt, ack[i], err[i], drd[i]);
                end
            end
        end
    end

    task automatic wait_term(input int i);
        int k;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if (ack[i] || err[i]) break;
        end
        if (k == 64) begin
            total++; bad++;
            $display("FAIL timeout inst=%0d got=no_term required=term", i);
        end
    endtask

    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit exp_err, input logic [31:0] exp_d);
        @(negedge clk);
        adr[i] = a; dwr[i] = d; sel[i] = s; we[i] = w;
        cyc[i] = 1'b1; stb[i] = 1'b1;
        sb.push_back('{inst: i, at_cycle: cyc_cnt + 1 + ws_of(i), is_err: exp_err,
                       chk: (!w && !exp_err), data: exp_d});
        wait_term(i);
        cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        we = '0; cyc = '0; stb = '0;
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0; dwr[i] = '0; sel[i] = '0;
        end
        // Request held through reset must not terminate until release.
        adr[0] = 32'h0; dwr[0] = 32'hCAFE_0000; sel[0] = 4'hF; we[0] = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (ack[i] !== 1'b0 || drd[i] !== 32'h0) begin
                    bad++;
                    $display("FAIL reset inst=%0d ack=%b dat=%h required ack=0 dat=0", i, ack[i], drd[i]);
                end
            end
        end
        rst_n = 1'b1;
        sb.push_back('{inst: 0, at_cycle: cyc_cnt + 2, is_err: 1'b0, chk: 1'b0, data: 32'h0});
        wait_term(0);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;

        // WAIT_STATES=1: basic write/read, address bits [1:0] ignored, byte lanes
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h13, 32'h0,         4'h1, 1'b0, 32'hDEAD_BEEF);
        xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        xfer(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h20, 32'h0,         4'h0, 1'b0, 32'h11BB_33DD);
        xfer(0, 1'b0, 32'h0,  32'h0,         4'hF, 1'b0, 32'hCAFE_0000);

`ifdef WB_SRAM_SLAVE_ERR_EN
        xfer(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 1'b1, 32'h0);
        xfer(0, 1'b0, 32'h0,    32'h0,         4'hF, 1'b0, 32'hCAFE_0000);
`else
        xfer(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'h0,    32'h0,         4'hF, 1'b0, 32'h1234_5678);
`endif

        // WAIT_STATES=3: abort a write by dropping cyc in the second wait cycle
        xfer(1, 1'b1, 32'h8, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        adr[1] = 32'h8; dwr[1] = 32'h5; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        repeat (6) @(negedge clk);
        xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'hA5A5_0001);

        // WAIT_STATES=0: strobe held 10 edges gives 5 acks on alternate cycles
        @(negedge clk);
        adr[2] = 32'h40; dwr[2] = 32'h77; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        c = cyc_cnt;
        for (int k = 0; k < 5; k++)
            sb.push_back('{inst: 2, at_cycle: c + 1 + 2 * k, is_err: 1'b0, chk: 1'b0, data: 32'h0});
        repeat (10) @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        xfer(2, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 32'h77);

        repeat (5) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
